// File: rtl/nes_clk_en_gen.sv
// Multi-channel clock-enable and reset-release generator for the NES core.
// Every channel divides clk_mst by a run-time divisor, starting at a run-time phase offset.
module nes_clk_en_gen #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned DIV_WIDTH = 5,
   parameter int unsigned RST_LEN   = 4
) (
   input  logic                          clk_mst,
   input  logic                          rst_mst_n,
   input  logic                          run,
   input  logic                          sync,
   input  logic [NUM_CH*DIV_WIDTH-1:0]   div,
   input  logic [NUM_CH*DIV_WIDTH-1:0]   phase,
   output logic [NUM_CH-1:0]             clk_en,
   output logic [NUM_CH-1:0]             rst_en,
   output logic                          rst_done
);

   localparam int unsigned RW = (RST_LEN < 1) ? 1 : $clog2(RST_LEN + 1);
   localparam logic [RW-1:0] RST_MAX = RW'(RST_LEN);

   logic              r_active;
   logic              r_rst_done;
   logic              w_load;
   logic [NUM_CH-1:0] w_rst_en_nxt;

   // Counters reload on a start edge or on a sync while already running.
   assign w_load   = (run & ~r_active) | (sync & r_active);
   assign rst_done = r_rst_done;

   always_ff @(posedge clk_mst or negedge rst_mst_n) begin
      if (!rst_mst_n) begin
         r_active   <= 1'b0;
         r_rst_done <= 1'b0;
      end else begin
         r_active   <= run;
         r_rst_done <= &(~w_rst_en_nxt);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DIV_WIDTH-1:0] w_div_in;
      logic [DIV_WIDTH-1:0] w_ph_in;
      logic [DIV_WIDTH-1:0] w_div_eff;
      logic [DIV_WIDTH-1:0] w_phase_eff;
      logic [DIV_WIDTH-1:0] w_cnt_nxt;
      logic [DIV_WIDTH-1:0] w_div_q_nxt;
      logic [RW-1:0]        w_rcnt_nxt;
      logic                 w_rst_nxt;
      logic [DIV_WIDTH-1:0] r_cnt;
      logic [DIV_WIDTH-1:0] r_div_q;
      logic [RW-1:0]        r_rcnt;
      logic                 r_clk_en;
      logic                 r_rst_en;

      assign w_div_in    = div[c*DIV_WIDTH +: DIV_WIDTH];
      assign w_ph_in     = phase[c*DIV_WIDTH +: DIV_WIDTH];
      assign w_div_eff   = (w_div_in < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : w_div_in;
      assign w_phase_eff = (w_ph_in > (w_div_eff - DIV_WIDTH'(1))) ?
                           (w_div_eff - DIV_WIDTH'(1)) : w_ph_in;

      // Next-state for the down-counter and the reset-release counter.
      always_comb begin
         w_cnt_nxt   = r_cnt;
         w_div_q_nxt = r_div_q;
         w_rcnt_nxt  = r_rcnt;
         w_rst_nxt   = r_rst_en;
         if (!run) begin
            w_rcnt_nxt = '0;
            w_rst_nxt  = 1'b1;
         end else begin
            if (w_load) begin
               w_cnt_nxt   = w_phase_eff;
               w_div_q_nxt = w_div_eff;
            end else if (r_cnt == '0) begin
               w_cnt_nxt   = w_div_eff - DIV_WIDTH'(1);
               w_div_q_nxt = w_div_eff;
            end else begin
               w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
            end
            if (r_clk_en && (r_rcnt < RST_MAX)) begin
               w_rcnt_nxt = r_rcnt + RW'(1);
            end
            w_rst_nxt = (w_rcnt_nxt < RST_MAX);
         end
      end

      always_ff @(posedge clk_mst or negedge rst_mst_n) begin
         if (!rst_mst_n) begin
            r_cnt    <= '0;
            r_div_q  <= DIV_WIDTH'(1);
            r_rcnt   <= '0;
            r_clk_en <= 1'b0;
            r_rst_en <= 1'b1;
         end else begin
            r_cnt    <= w_cnt_nxt;
            r_div_q  <= w_div_q_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_clk_en <= run & (w_cnt_nxt == '0);
            r_rst_en <= w_rst_nxt;
         end
      end

      // The counter always stays below the latched period.
      always_ff @(posedge clk_mst) begin
         if (rst_mst_n) begin
            assert (r_cnt < r_div_q);
         end
      end

      assign clk_en[c]       = r_clk_en;
      assign rst_en[c]       = r_rst_en;
      assign w_rst_en_nxt[c] = w_rst_nxt;
   end

endmodule

// File: tb/tb_nes_clk_en_gen.sv
// Directed self-checking bench for nes_clk_en_gen (NUM_CH=2, DIV_WIDTH=5, RST_LEN=4).
module tb_nes_clk_en_gen;

   logic       clk_mst   = 1'b0;
   logic       rst_mst_n = 1'b0;
   logic       run       = 1'b0;
   logic       sync      = 1'b0;
   logic [9:0] div       = '0;
   logic [9:0] phase     = '0;
   logic [1:0] clk_en;
   logic [1:0] rst_en;
   logic       rst_done;
   int         checks    = 0;
   int         errors    = 0;

   always #5 clk_mst = ~clk_mst;

   nes_clk_en_gen #(.NUM_CH(2), .DIV_WIDTH(5), .RST_LEN(4)) dut (
      .clk_mst   (clk_mst),
      .rst_mst_n (rst_mst_n),
      .run       (run),
      .sync      (sync),
      .div       (div),
      .phase     (phase),
      .clk_en    (clk_en),
      .rst_en    (rst_en),
      .rst_done  (rst_done)
   );

   task automatic do_reset();
      @(negedge clk_mst);
      run = 1'b0; sync = 1'b0; rst_mst_n = 1'b0;
      @(negedge clk_mst);
      rst_mst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk_mst);
      checks++;
      if ({clk_en, rst_en, rst_done} !== 5'b00_11_0) begin
         errors++;
         $display("FAIL reset_in got=%b exp=%b", {clk_en, rst_en, rst_done}, 5'b00_11_0);
      end
      rst_mst_n = 1'b1;
      div = {5'd4, 5'd12};
      for (int n = 0; n < 3; n++) begin
         @(posedge clk_mst); @(negedge clk_mst);
         checks++;
         if ({clk_en, rst_en, rst_done} !== 5'b00_11_0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%b exp=%b", n, {clk_en, rst_en, rst_done}, 5'b00_11_0);
         end
      end
   endtask

   task automatic test_nes_start();
      logic [1:0] e_en, e_rst;
      do_reset();
      div = {5'd4, 5'd12}; phase = '0; run = 1'b1;
      for (int n = 0; n <= 40; n++) begin
         @(posedge clk_mst); @(negedge clk_mst);
         e_en  = {(n % 4) == 0, (n % 12) == 0};
         e_rst = {n < 13, n < 37};
         checks++;
         if (clk_en !== e_en) begin
            errors++;
            $display("FAIL start_clk_en cyc=%0d got=%b exp=%b", n, clk_en, e_en);
         end
         checks++;
         if (rst_en !== e_rst) begin
            errors++;
            $display("FAIL start_rst_en cyc=%0d got=%b exp=%b", n, rst_en, e_rst);
         end
         checks++;
         if (rst_done !== (n >= 37)) begin
            errors++;
            $display("FAIL start_rst_done cyc=%0d got=%b exp=%b", n, rst_done, n >= 37);
         end
      end
   endtask

   task automatic test_div_change();
      logic e1;
      do_reset();
      div = {5'd4, 5'd12}; phase = '0; run = 1'b1;
      for (int n = 0; n <= 22; n++) begin
         @(posedge clk_mst); @(negedge clk_mst);
         e1 = (n == 0) || (n == 4) || ((n >= 10) && ((n - 10) % 6 == 0));
         checks++;
         if (clk_en[1] !== e1) begin
            errors++;
            $display("FAIL divchg_ch1 cyc=%0d got=%b exp=%b", n, clk_en[1], e1);
         end
         if (n == 2) div[9:5] = 5'd6;
      end
   endtask

   // Runs cycles 0..49 and leaves run low so edge 50 stops the channels.
   task automatic test_phase_sync();
      logic [1:0] e_en, e_rst;
      do_reset();
      div = {5'd4, 5'd12}; phase = {5'd2, 5'd5}; run = 1'b1;
      for (int n = 0; n <= 49; n++) begin
         @(posedge clk_mst); @(negedge clk_mst);
         e_en[0] = (n == 5) || (n == 17) || ((n >= 20) && ((n - 20) % 12 == 0));
         e_en[1] = (n >= 2) && ((n - 2) % 4 == 0);
         e_rst   = {n < 15, n < 33};
         checks++;
         if (clk_en !== e_en) begin
            errors++;
            $display("FAIL phsync_clk_en cyc=%0d got=%b exp=%b", n, clk_en, e_en);
         end
         checks++;
         if (rst_en !== e_rst) begin
            errors++;
            $display("FAIL phsync_rst_en cyc=%0d got=%b exp=%b", n, rst_en, e_rst);
         end
         sync = 1'b0;
         if (n == 19) begin
            sync = 1'b1;
            phase[4:0] = 5'd0;
         end
         if (n == 49) run = 1'b0;
      end
   endtask

   task automatic test_stop_restart();
      logic [1:0] e_en, e_rst;
      logic       e_done;
      for (int n = 50; n <= 100; n++) begin
         @(posedge clk_mst); @(negedge clk_mst);
         if (n < 60) begin
            e_en = 2'b00; e_rst = 2'b11; e_done = 1'b0;
         end else begin
            e_en[0] = ((n - 60) % 12) == 0;
            e_en[1] = (n >= 62) && ((n - 62) % 4 == 0);
            e_rst   = {n < 75, n < 97};
            e_done  = (n >= 97);
         end
         checks++;
         if (clk_en !== e_en) begin
            errors++;
            $display("FAIL stop_clk_en cyc=%0d got=%b exp=%b", n, clk_en, e_en);
         end
         checks++;
         if ({rst_en, rst_done} !== {e_rst, e_done}) begin
            errors++;
            $display("FAIL stop_rst cyc=%0d got=%b exp=%b", n, {rst_en, rst_done}, {e_rst, e_done});
         end
         if (n == 59) run = 1'b1;
      end
   endtask

   task automatic test_degenerate();
      logic [2:0] e_rst;
      do_reset();
      div = {5'd0, 5'd1}; phase = {5'd7, 5'd3}; run = 1'b1;
      for (int n = 0; n <= 8; n++) begin
         @(posedge clk_mst); @(negedge clk_mst);
         e_rst = (n < 4) ? 3'b110 : 3'b001;
         checks++;
         if (clk_en !== 2'b11) begin
            errors++;
            $display("FAIL degen_clk_en cyc=%0d got=%b exp=%b", n, clk_en, 2'b11);
         end
         checks++;
         if ({rst_en, rst_done} !== e_rst) begin
            errors++;
            $display("FAIL degen_rst cyc=%0d got=%b exp=%b", n, {rst_en, rst_done}, e_rst);
         end
      end
   endtask

   task automatic test_phase_clamp();
      logic e0;
      do_reset();
      div = {5'd4, 5'd12}; phase = {5'd0, 5'd20}; run = 1'b1;
      for (int n = 0; n <= 36; n++) begin
         @(posedge clk_mst); @(negedge clk_mst);
         e0 = (n >= 11) && ((n - 11) % 12 == 0);
         checks++;
         if (clk_en[0] !== e0) begin
            errors++;
            $display("FAIL clamp_ch0 cyc=%0d got=%b exp=%b", n, clk_en[0], e0);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      div = {5'd4, 5'd12}; phase = '0; run = 1'b1;
      @(posedge clk_mst); #1;
      checks++;
      if (clk_en !== 2'b11) begin
         errors++;
         $display("FAIL arst_pre got=%b exp=%b", clk_en, 2'b11);
      end
      #1 rst_mst_n = 1'b0;
      #1;
      checks++;
      if ({clk_en, rst_en, rst_done} !== 5'b00_11_0) begin
         errors++;
         $display("FAIL arst_now got=%b exp=%b", {clk_en, rst_en, rst_done}, 5'b00_11_0);
      end
      @(negedge clk_mst); run = 1'b0;
      @(negedge clk_mst); rst_mst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk_mst); @(negedge clk_mst);
         checks++;
         if (clk_en !== 2'b00) begin
            errors++;
            $display("FAIL arst_idle cyc=%0d got=%b exp=%b", n, clk_en, 2'b00);
         end
      end
      run = 1'b1;
      @(posedge clk_mst); @(negedge clk_mst);
      checks++;
      if ({clk_en, rst_en} !== 4'b11_11) begin
         errors++;
         $display("FAIL arst_restart got=%b exp=%b", {clk_en, rst_en}, 4'b11_11);
      end
   endtask

   initial begin
      test_reset();
      test_nes_start();
      test_div_change();
      test_phase_sync();
      test_stop_restart();
      test_degenerate();
      test_phase_clamp();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
